sub_serial: RTL and testbench



---
 rtl/sub_pkg.sv | 14 +
 rtl/fs_digit.sv | 34 +++
 rtl/sub_serial.sv | 153 +++++++++++++++
 tb/tb_sub_serial.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types for the digit-serial subtractor.
package sub_pkg;

  // Control states of the serial subtractor.
  //   IDLE : waiting for operands
  //   RUN  : one digit processed per clock
  //   DONE : result presented, waiting for the consumer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : sub_pkg

// File: rtl/fs_digit.sv
// Combinational D-bit ripple-borrow subtractor: dif = x - y - bin.
// Built from a chain of one-bit full subtractors; bout is the borrow
// leaving the most significant bit.
module fs_digit #(
  parameter int D = 4
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         bin,
  output logic [D-1:0] dif,
  output logic         bout
);

  // Borrow entering each bit position; brw[D] leaves the digit.
  logic [D:0] brw;

  // Ripple the borrow from the LSB upwards through one-bit full subtractors.
  always_comb begin
    // NOTE: every variable driven here gets a value before any branch or
    // loop reads it, so no path can leave it unassigned and infer a latch.
    dif    = '0;
    brw    = '0;
    brw[0] = bin;
    for (int i = 0; i < D; i++) begin
      dif[i]     = x[i] ^ y[i] ^ brw[i];
      // Borrow when x < y + borrow at this bit: x=0,y=1, or x==y with a
      // borrow already coming in.
      brw[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
    end
  end

  assign bout = brw[D];

endmodule : fs_digit

// File: rtl/sub_serial.sv
// Digit-serial subtractor: d = a - b - bi over N bits, D bits per clock.
// Operands are captured on an input handshake, consumed LSB digit first
// through a registered borrow, and the result is held on the output
// handshake until the consumer takes it.
module sub_serial
  import sub_pkg::*;
#(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bo,
  output logic         ov
);

  // Number of RUN cycles per operation and the counter that tracks them.
  localparam int STEPS = N / D;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  // Reject widths that cannot be split into whole digits.
  if (D < 1 || D > N || (N % D) != 0) begin : g_param_check
    $error("sub_serial: D must satisfy 1 <= D <= N and divide N exactly");
  end

  state_t state;
  state_t state_nxt;

  logic [N-1:0]  a_sh;       // remaining minuend digits, LSB digit next
  logic [N-1:0]  b_sh;       // remaining subtrahend digits, LSB digit next
  logic          brw;        // borrow carried between digits
  logic          a_sign;     // a[N-1] at capture, for overflow
  logic          b_sign;     // b[N-1] at capture, for overflow
  logic [CW-1:0] cnt;        // digits already processed

  logic          load;       // operands accepted on this edge
  logic          last_step;  // current RUN cycle handles the top digit
  logic [D-1:0]  dig_dif;
  logic          dig_bout;
  logic [N-1:0]  d_next;     // d with this cycle's digit shifted in on top

  assign load      = in_valid && in_ready;
  assign last_step = (state == RUN) && (cnt == LAST);

  // One digit of the subtraction per clock.
  fs_digit #(
    .D (D)
  ) u_digit (
    .x    (a_sh[D-1:0]),
    .y    (b_sh[D-1:0]),
    .bin  (brw),
    .dif  (dig_dif),
    .bout (dig_bout)
  );

  // New digit enters at the top of d; after STEPS shifts the first digit
  // has reached the bottom and d is fully aligned.
  always_comb begin
    d_next = N'({dig_dif, d} >> D);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state always uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        // Retire; a waiting operand set starts immediately (back-to-back).
        if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      RUN:  in_ready = 1'b0;
      DONE: begin
        out_valid = 1'b1;
        // A new operation may start on the same edge the result is retired.
        in_ready  = out_ready;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture, digit shifting and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      brw    <= 1'b0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bo     <= 1'b0;
      ov     <= 1'b0;
    end else if (load) begin
      a_sh   <= a;
      b_sh   <= b;
      brw    <= bi;
      a_sign <= a[N-1];
      b_sign <= b[N-1];
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> D;
      b_sh <= b_sh >> D;
      brw  <= dig_bout;
      d    <= d_next;
      cnt  <= cnt + CW'(1);
      if (last_step) begin
        bo <= dig_bout;
        // Overflow: operands of opposite sign and the result's sign differs
        // from the minuend's.
        ov <= (a_sign != b_sign) && (d_next[N-1] != a_sign);
      end
    end
  end

endmodule : sub_serial

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial. Three instances (D = 4, 1, 16 at
// N = 16) share the operand bus; each has its own handshake signals.
module tb_sub_serial;

  localparam int N  = 16;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] a_s;
  logic [N-1:0] b_s;
  logic         bi_s;

  logic         iv   [NI];
  logic         ir   [NI];
  logic         ovld [NI];
  logic         ordy [NI];
  logic [N-1:0] d_o  [NI];
  logic         bo_o [NI];
  logic         ov_o [NI];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sub_serial #(.N(N), .D(4)) u_dut_d4 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv[0]), .in_ready (ir[0]),
    .a (a_s), .b (b_s), .bi (bi_s),
    .out_valid (ovld[0]), .out_ready (ordy[0]),
    .d (d_o[0]), .bo (bo_o[0]), .ov (ov_o[0])
  );

  sub_serial #(.N(N), .D(1)) u_dut_d1 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv[1]), .in_ready (ir[1]),
    .a (a_s), .b (b_s), .bi (bi_s),
    .out_valid (ovld[1]), .out_ready (ordy[1]),
    .d (d_o[1]), .bo (bo_o[1]), .ov (ov_o[1])
  );

  sub_serial #(.N(N), .D(16)) u_dut_d16 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv[2]), .in_ready (ir[2]),
    .a (a_s), .b (b_s), .bi (bi_s),
    .out_valid (ovld[2]), .out_ready (ordy[2]),
    .d (d_o[2]), .bo (bo_o[2]), .ov (ov_o[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int steps_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  // Reference: {ov, bo, d} from plain 17-bit arithmetic.
  function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
    logic [16:0] t;
    logic [15:0] dd;
    logic        o;
    t  = {1'b0, x} - {1'b0, y} - 17'(c);
    dd = t[15:0];
    o  = (x[15] != y[15]) && (dd[15] != x[15]);
    return {o, t[16], dd};
  endfunction

  // Operand generator biased towards boundary values.
  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Present operands on a negedge once the instance is ready; returns at the
  // negedge after the accept edge with in_valid dropped and the bus scrambled.
  task automatic issue(input int idx, input logic [15:0] aa, input logic [15:0] bb,
                       input logic bbi);
    int w = 0;
    while (!ir[idx] && w < 64) begin
      @(negedge clk);
      w++;
    end
    check("issue_ready", 32'(ir[idx]), 32'd1);
    a_s     = aa;
    b_s     = bb;
    bi_s    = bbi;
    iv[idx] = 1'b1;
    @(negedge clk);
    iv[idx] = 1'b0;
    a_s     = 16'($urandom);
    b_s     = 16'($urandom);
    bi_s    = 1'($urandom_range(0, 1));
  endtask

  // Count edges after the accept edge until out_valid, then compare result.
  task automatic await_result(input int idx, input logic [15:0] ed, input logic ebo,
                              input logic eov);
    int n = 0;
    while (!ovld[idx] && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(steps_of(idx)));
    check("d", 32'(d_o[idx]), 32'(ed));
    check("bo", 32'(bo_o[idx]), 32'(ebo));
    check("ov", 32'(ov_o[idx]), 32'(eov));
  endtask

  task automatic retire(input int idx);
    ordy[idx] = 1'b1;
    @(negedge clk);
    ordy[idx] = 1'b0;
    check("idle_after_retire", 32'(ovld[idx]), 32'd0);
  endtask

  task automatic do_op(input int idx, input logic [15:0] aa, input logic [15:0] bb,
                       input logic bbi, input logic [15:0] ed, input logic ebo,
                       input logic eov, input int hold);
    issue(idx, aa, bb, bbi);
    await_result(idx, ed, ebo, eov);
    repeat (hold) @(negedge clk);
    retire(idx);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] r;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    for (int i = 0; i < NI; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b0;
    end
    a_s  = '0;
    b_s  = '0;
    bi_s = 1'b0;

    // Reset state, during and after reset.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(ovld[0]), 32'd0);
    check("rst_in_ready", 32'(ir[0]), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", 32'({ovld[0], ir[0], bo_o[0], ov_o[0], d_o[0]}), 32'h4_0000);
    check("rst_ready_d1", 32'(ir[1]), 32'd1);
    check("rst_ready_d16", 32'(ir[2]), 32'd1);

    // Directed scenarios on the D=4 instance.
    do_op(0, 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 0);
    do_op(0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op(0, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op(0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
    do_op(0, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 0);

    // Backpressure: result held for 10 cycles, then back-to-back retire+accept.
    issue(0, 16'h4321, 16'h1111, 1'b1);
    await_result(0, 16'h320F, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", 32'({ovld[0], ir[0], bo_o[0], ov_o[0], d_o[0]}), 32'h8_320F);
    end
    ordy[0] = 1'b1;
    issue(0, 16'h0100, 16'h0200, 1'b0);
    ordy[0] = 1'b0;
    check("b2b_running", 32'(ovld[0]), 32'd0);
    await_result(0, 16'hFF00, 1'b1, 1'b0);
    retire(0);

    // Asynchronous reset in the second RUN cycle.
    issue(0, 16'hFFFF, 16'h0000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(ovld[0]), 32'd0);
    check("mid_rst_in_ready", 32'(ir[0]), 32'd1);
    check("mid_rst_d", 32'(d_o[0]), 32'd0);
    check("mid_rst_bo_ov", 32'({bo_o[0], ov_o[0]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_output_after_rst", 32'(ovld[0]), 32'd0);
    do_op(0, 16'hABCD, 16'h1111, 1'b0, 16'h9ABC, 1'b0, 1'b0, 0);

    // Randomised sweep on every instance against the reference model.
    for (int idx = 0; idx < NI; idx++) begin
      for (int k = 0; k < ((idx == 0) ? 1000 : 400); k++) begin
        ra = rand_op();
        rb = rand_op();
        rc = 1'($urandom_range(0, 1));
        r  = ref_sub(ra, rb, rc);
        do_op(idx, ra, rb, rc, r[15:0], r[16], r[17], int'($urandom_range(0, 2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_sub_serial
